// File: rtl/mul32_arb.sv
// Round-robin arbiter that time-shares one external mul32 multiplier between N requesters.
// Operands are held on the multiplier for the whole run; the product comes back tagged with the requester ID.
module mul32_arb #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  output logic [N-1:0]      ack,
  input  logic [N*32-1:0]   req_mc,
  input  logic [N*32-1:0]   req_mp,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_p,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [31:0]       mul_mc,
  output logic [31:0]       mul_mp,
  input  logic [31:0]       mul_p,
  input  logic              mul_done
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   gid_q;
  logic [CW-1:0]    cnt_q;
  logic [N-1:0]     ack_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [31:0]      rsp_p_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic             start_q;
  logic [31:0]      mc_q;
  logic [31:0]      mp_q;

  logic             win_vld_d;
  logic [IDW-1:0]   win_d;
  logic [IDW:0]     cand_d;
  logic [IDW-1:0]   ptr_d;

  // Scan ptr, ptr+1, ... wrapping modulo N; first set request wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = '0;
    cand_d    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand_d = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand_d >= (IDW+1)'(N)) begin
        cand_d = cand_d - (IDW+1)'(N);
      end
      if (!win_vld_d && req[cand_d[IDW-1:0]]) begin
        win_vld_d = 1'b1;
        win_d     = cand_d[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = (gid_q == IDW'(N-1)) ? '0 : gid_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      mc_q        <= '0;
      mp_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            gid_q   <= win_d;
            mc_q    <= req_mc[32*int'(win_d) +: 32];
            mp_q    <= req_mp[32*int'(win_d) +: 32];
            start_q <= 1'b1;
            ack_q   <= N'(1) << win_d;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          ack_q   <= '0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A done arriving on the timeout cycle still delivers its product.
          if (mul_done) begin
            rsp_p_q     <= mul_p;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= gid_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == CW'(TIMEOUT-1)) begin
            rsp_p_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_id_q    <= gid_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          ptr_q       <= ptr_d;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign mul_start = start_q;
  assign mul_mc    = mc_q;
  assign mul_mp    = mp_q;

endmodule

// File: tb/tb_mul32_arb.sv
// Bench for mul32_arb: behavioural multiplier, cycle model of the arbiter, and literal response expectations.
module tb_mul32_arb;

  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 63;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    ack;
  logic [N*32-1:0] req_mc;
  logic [N*32-1:0] req_mp;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_p;
  logic            rsp_err;
  logic            busy;
  logic            mul_start;
  logic [31:0]     mul_mc;
  logic [31:0]     mul_mp;
  logic [31:0]     mul_p;
  logic            mul_done;

  always #5 clk = ~clk;

  mul32_arb #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .req_mc(req_mc), .req_mp(req_mp),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_err(rsp_err),
    .busy(busy), .mul_start(mul_start), .mul_mc(mul_mc), .mul_mp(mul_mp),
    .mul_p(mul_p), .mul_done(mul_done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          id;
    logic [31:0] p;
    bit          err;
    int          lat;
  } lit_t;

  lit_t lit [0:31];
  int   lit_n     = 0;
  int   lit_rd    = 0;
  int   resp_seen = 0;
  int   start_cyc = 0;
  bit   hang      = 1'b0;
  bit   hang_seen = 1'b0;
  bit   dead      = 1'b0;
  int   mul_lat   = 33;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Multiplier stand-in: product appears mul_lat cycles after the start pulse, computed from the held operands.
  initial begin
    int l;
    mul_done = 1'b0;
    mul_p    = '0;
    forever begin
      @(negedge clk);
      if (mul_start === 1'b1 && !dead) begin
        l = mul_lat;
        repeat (l) @(negedge clk);
        mul_p    = mul_mc * mul_mp;
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
        mul_p    = '0;
      end
    end
  end

  // Job model: age counts edges since the grant; the job may complete from its third edge on.
  bit              m_on = 1'b0;
  bit              m_job, m_resp, m_err;
  int              m_age, m_ptr, m_id;
  logic [31:0]     m_mc, m_mp, m_rp;
  logic [IDW-1:0]  m_rid;
  logic [N-1:0]    s_req, e_ack;
  logic [N*32-1:0] s_mc, s_mp;
  logic            s_rst, s_done;
  logic [31:0]     s_p;
  bit              found;

  always begin
    @(posedge clk);
    s_rst = rst; s_req = req; s_mc = req_mc; s_mp = req_mp; s_done = mul_done; s_p = mul_p;
    cyc++;
    if (s_rst !== 1'b1) begin
      m_on = 1'b1; m_job = 1'b0; m_resp = 1'b0; m_err = 1'b0;
      m_age = 0; m_ptr = 0; m_id = 0;
      m_mc = '0; m_mp = '0; m_rp = '0; m_rid = '0;
    end else if (m_on) begin
      if (m_resp) begin
        m_resp = 1'b0;
        m_ptr  = (m_id + 1) % N;
      end else if (m_job) begin
        m_age++;
        if (m_age >= 3 && (s_done === 1'b1 || m_age == TIMEOUT + 2)) begin
          m_job  = 1'b0;
          m_resp = 1'b1;
          m_rid  = IDW'(m_id);
          m_err  = (s_done !== 1'b1);
          m_rp   = m_err ? 32'h0 : s_p;
        end
      end else if (s_req != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && s_req[(m_ptr + k) % N]) begin
            found = 1'b1;
            m_id  = (m_ptr + k) % N;
          end
        end
        m_job = 1'b1;
        m_age = 1;
        m_mc  = s_mc[m_id*32 +: 32];
        m_mp  = s_mp[m_id*32 +: 32];
      end
    end
    #1;
    if (m_on) begin
      e_ack = (m_job && m_age == 1) ? (N'(1) << m_id) : '0;
      check("ack",        32'(ack),        32'(e_ack));
      check("ack_onehot", 32'($countones(ack) <= 1), 32'(1));
      check("mul_start",  32'(mul_start),  32'(m_job && m_age == 1));
      check("busy",       32'(busy),       32'(m_job || m_resp));
      check("rsp_valid",  32'(rsp_valid),  32'(m_resp));
      check("mul_mc",     mul_mc,          m_mc);
      check("mul_mp",     mul_mp,          m_mp);
      check("rsp_id",     32'(rsp_id),     32'(m_rid));
      check("rsp_p",      rsp_p,           m_rp);
      check("rsp_err",    32'(rsp_err),    32'(m_err));
      if (mul_start === 1'b1) start_cyc = cyc;
      if (rsp_valid === 1'b1) begin
        resp_seen++;
        if (lit_rd < lit_n) begin
          check("lit_id",  32'(rsp_id),  32'(lit[lit_rd].id));
          check("lit_p",   rsp_p,        lit[lit_rd].p);
          check("lit_err", 32'(rsp_err), 32'(lit[lit_rd].err));
          if (lit[lit_rd].lat >= 0) check("lit_lat", 32'(cyc - start_cyc), 32'(lit[lit_rd].lat));
          lit_rd++;
        end
      end
    end
    if (hang && !hang_seen) begin
      hang_seen = 1'b1;
      tests++;
      fails++;
      $display("FAIL watchdog: got %0d responses by cycle %0d, wanted %0d", resp_seen, cyc, lit_n);
    end
  end

  task automatic set_op(input int i, input logic [31:0] mc, input logic [31:0] mp);
    req_mc[i*32 +: 32] = mc;
    req_mp[i*32 +: 32] = mp;
  endtask

  task automatic expect_rsp(input int id, input logic [31:0] p, input bit err, input int lat);
    lit[lit_n] = '{id, p, err, lat};
    lit_n++;
  endtask

  task automatic serve(input int n, input bit drop);
    int target = resp_seen + n;
    int budget = 300 * n;
    while (resp_seen < target && budget > 0) begin
      @(negedge clk);
      if (drop) req = req & ~ack;
      budget--;
    end
    if (resp_seen < target) hang = 1'b1;
  endtask

  task automatic wait_ack(input int i);
    int budget = 50;
    while (ack[i] !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (ack[i] !== 1'b1) hang = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    req    = '0;
    req_mc = '0;
    req_mp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single request
    set_op(0, 32'd3, 32'd5);
    expect_rsp(0, 32'd15, 1'b0, 34);
    req = 4'b0001;
    serve(1, 1'b1);

    // signed operands; slice changes after the ack must not reach the multiplier
    set_op(2, 32'hFFFF_FFF9, 32'd6);
    expect_rsp(2, 32'hFFFF_FFD6, 1'b0, 34);
    req = 4'b0100;
    wait_ack(2);
    req = '0;
    set_op(2, 32'h1234_5678, 32'h0);
    serve(1, 1'b0);

    // contention from ptr=0 with all requests held
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    set_op(0, 32'd10,        32'd4);
    set_op(1, 32'hFFFF_FFFD, 32'd5);
    set_op(2, 32'd7,         32'hFFFF_FFF7);
    set_op(3, 32'd100000,    32'd70000);
    expect_rsp(0, 32'd40,        1'b0, 34);
    expect_rsp(1, 32'hFFFF_FFF1, 1'b0, 34);
    expect_rsp(2, 32'hFFFF_FFC1, 1'b0, 34);
    expect_rsp(3, 32'hA13B_8600, 1'b0, 34);
    expect_rsp(0, 32'd40,        1'b0, 34);
    req = 4'b1111;
    serve(5, 1'b0);
    req = '0;

    // rotation: after serving 1, requester 3 beats 0
    set_op(1, 32'd11, 32'hFFFF_FFFE);
    expect_rsp(1, 32'hFFFF_FFEA, 1'b0, 34);
    req = 4'b0010;
    serve(1, 1'b1);
    set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_op(0, 32'h7FFF_FFFF, 32'd2);
    expect_rsp(3, 32'd1,         1'b0, 34);
    expect_rsp(0, 32'hFFFF_FFFE, 1'b0, 34);
    req = 4'b1001;
    serve(2, 1'b1);

    // lost mul_done, then normal service
    dead = 1'b1;
    set_op(2, 32'd4, 32'd4);
    expect_rsp(2, 32'd0, 1'b1, TIMEOUT + 1);
    req = 4'b0100;
    serve(1, 1'b1);
    dead = 1'b0;
    set_op(1, 32'd6, 32'd7);
    expect_rsp(1, 32'd42, 1'b0, 34);
    req = 4'b0010;
    serve(1, 1'b1);

    // mul_done on the timeout cycle wins
    mul_lat = TIMEOUT;
    set_op(0, 32'd5, 32'hFFFF_FFFB);
    expect_rsp(0, 32'hFFFF_FFE7, 1'b0, TIMEOUT + 1);
    req = 4'b0001;
    serve(1, 1'b1);
    mul_lat = 33;

    // reset in WAIT: late done ignored, ptr back to 0
    set_op(2, 32'd9, 32'd9);
    req = 4'b0100;
    wait_ack(2);
    req = '0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    set_op(1, 32'hFFFF_FF9C, 32'hFFFF_FF9C);
    set_op(3, 32'd0, 32'd12345);
    expect_rsp(1, 32'h0000_2710, 1'b0, 34);
    expect_rsp(3, 32'd0,         1'b0, 34);
    req = 4'b1010;
    serve(2, 1'b1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul32_arb.md
Name: mul32_arb

Overview:
- Round-robin arbiter and sequencer that shares one mul32 signed multiplier between N requesters.
- Accepts operand pairs from requesters and launches one multiplication at a time.
- Holds the operands stable on the multiplier for the whole run, then returns the 32-bit product tagged with the requester ID.
- Sits between client blocks and a single mul32 instance. Top level inverts rst for mul32's active-high reset.

Parameters:
N, 4, number of requesters (2..8)
IDW, 2, requester-ID width; 2^IDW >= N
TIMEOUT, 63, max WAIT cycles before mul_done is declared lost (must exceed 34)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
req  in  N  request per requester; held until matching ack
ack  out  N  one-cycle pulse: operands of that requester captured
req_mc  in  N*32  multiplicands, requester i at bits [32i+31:32i]
req_mp  in  N*32  multipliers, same packing
rsp_valid  out  1  one-cycle pulse: rsp_id/rsp_p/rsp_err valid
rsp_id  out  IDW  requester served
rsp_p  out  32  product (low 32 bits, signed)
rsp_err  out  1  timeout flag, qualified by rsp_valid
busy  out  1  high in every state except IDLE
mul_start  out  1  start pulse to mul32
mul_mc  out  32  multiplicand to mul32
mul_mp  out  32  multiplier to mul32
mul_p  in  32  product from mul32
mul_done  in  1  done from mul32

Behaviour:
- All outputs are registered.
- Reset (rst=0 at an edge) applies from any state, including mid-operation. Next cycle:
  - state=IDLE, ptr=0.
  - ack, rsp_valid, rsp_err, mul_start, busy = 0.
  - rsp_id, rsp_p, mul_mc, mul_mp = 0.
  - An in-flight mul32 result is abandoned; a later mul_done is ignored in IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, the winner is the first set bit scanning ptr, ptr+1, … wrapping modulo N.
  - Latch gid=winner, mul_mc/mul_mp from its slice, and set mul_start=1 and ack[gid]=1 for the next cycle.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE (1 cycle): mul_start=1, ack[gid]=1. Clear the timeout counter and go to WAIT.
- WAIT:
  - mul_start=0, ack=0; mul_mc/mul_mp stay unchanged (mul32 samples mc every cycle).
  - Counter increments each cycle.
  - On mul_done=1: rsp_p<=mul_p, rsp_err<=0, go to RESP.
  - Else if counter==TIMEOUT-1: rsp_p<=0, rsp_err<=1, go to RESP.
  - If mul_done and timeout coincide, mul_done wins.
- RESP (1 cycle):
  - rsp_valid=1, rsp_id=gid.
  - ptr<=(gid+1) mod N, go to IDLE.
  - rsp_p/rsp_id/rsp_err hold until the next RESP.
- Throughput: at most one grant per 4+mul32 latency cycles. IDLE lasts a single cycle when a request is pending.
- Requester rules:
  - Holding req after its ack counts as a new request; it is re-arbitrated after RESP, and round-robin places it last.
  - Dropping req before ack is a protocol violation; behaviour is unspecified.
  - Operand slices need only be stable on the cycle the requester wins in IDLE.
- Arithmetic: none locally; product semantics are mul32's (signed, truncated to 32 bits).

Test Plan:
- Single request: req=0001, mc=3, mp=5 -> ack[0] one pulse, one mul_start pulse, rsp_valid with rsp_id=0, rsp_p=15, rsp_err=0; busy low after RESP.
- Signed operands: requester 2 sends mc=-7 (0xFFFFFFF9), mp=6 -> rsp_id=2, rsp_p=0xFFFFFFD6; mul_mc stays 0xFFFFFFF9 through all of WAIT.
- Contention: req=1111 held constant after reset with distinct operands -> responses in order IDs 0,1,2,3,0; products match per ID; never two acks at once.
- Rotation: serve requester 1 (ptr becomes 2), then assert req=1001 -> requester 3 granted before 0.
- Timeout: multiplier model never asserts mul_done -> rsp_valid exactly TIMEOUT cycles after entering WAIT, rsp_err=1, rsp_p=0; next request served normally.
- Reset mid-WAIT: rst=0 for one cycle during WAIT -> all outputs 0 next cycle; a late mul_done pulse yields no rsp_valid; first grant afterwards goes to the lowest requesting ID (ptr=0).
